// File: rtl/ram_fifo_ctrl_if.sv
// Bundle of FIFO handshake, status and RAM-port signals shared by the controller and its user.
// The slave modport is the controller; the master modport is the user plus the RAM read-data return.
interface ram_fifo_ctrl_if #(
  parameter int DW = 16,
  parameter int AW = 3
);
  logic          push;
  logic [DW-1:0] din;
  logic          pop;
  logic          err_clr;
  logic          ram_we;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_din;
  logic          ram_re;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_dout;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  // Handshake: a push/pop request is taken in the cycle it is high if the FIFO
  // can accept it (ram_we/ram_re show acceptance); read data arrives on dout
  // one cycle after an accepted pop, marked by dout_valid.
  modport slave (
    input  push, din, pop, err_clr, ram_dout,
    output ram_we, ram_wr_addr, ram_din, ram_re, ram_rd_addr,
           dout, dout_valid, full, empty, almost_full, count,
           overflow, underflow
  );

  modport master (
    output push, din, pop, err_clr, ram_dout,
    input  ram_we, ram_wr_addr, ram_din, ram_re, ram_rd_addr,
           dout, dout_valid, full, empty, almost_full, count,
           overflow, underflow
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving an external dual-port RAM with registered read output.
// Tracks occupancy, generates RAM port controls, read-valid strobe and sticky error flags.
module ram_fifo_ctrl #(
  parameter int DW       = 16,
  parameter int AW       = 3,
  parameter int AFULL_TH = 6
) (
  input  logic            clk,
  input  logic            clr_n,
  ram_fifo_ctrl_if.slave  bus
);
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(1 << AW);
  localparam logic [AW:0] LP_AFULL = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] LP_ONE   = (AW+1)'(1);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_dout_valid;
  logic          r_overflow;
  logic          r_underflow;

  logic          w_full;
  logic          w_empty;
  logic          w_almost_full;
  logic          w_push_ok;
  logic          w_pop_ok;
  logic          w_ovf_set;
  logic          w_unf_set;
  logic [AW:0]   w_count_nxt;
  logic [DW-1:0] w_din;
  logic [DW-1:0] w_rdata;

  // Status flags decode only from the registered count, so they never glitch.
  always_comb begin
    w_full        = (r_count == LP_DEPTH);
    w_empty       = (r_count == '0);
    w_almost_full = (r_count >= LP_AFULL);
  end

  // A pop on a full FIFO frees a slot in the same cycle, so a push is still taken.
  always_comb begin
    w_pop_ok  = bus.pop & ~w_empty;
    w_push_ok = bus.push & (~w_full | w_pop_ok);
    w_ovf_set = bus.push & w_full & ~w_pop_ok;
    w_unf_set = bus.pop & w_empty;
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_nxt = r_count + LP_ONE;
      2'b01:   w_count_nxt = r_count - LP_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count      <= w_count_nxt;
      r_dout_valid <= w_pop_ok;
    end
  end

  // A new error in the same cycle as err_clr must survive the clear.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_set)        r_overflow <= 1'b1;
      else if (bus.err_clr) r_overflow <= 1'b0;
      if (w_unf_set)        r_underflow <= 1'b1;
      else if (bus.err_clr) r_underflow <= 1'b0;
    end
  end

  assign w_din   = bus.din;
  assign w_rdata = bus.ram_dout;

  assign bus.ram_we      = w_push_ok;
  assign bus.ram_wr_addr = r_wr_ptr;
  assign bus.ram_din     = w_din;
  assign bus.ram_re      = w_pop_ok;
  assign bus.ram_rd_addr = r_rd_ptr;
  assign bus.dout        = w_rdata;
  assign bus.dout_valid  = r_dout_valid;
  assign bus.full        = w_full;
  assign bus.empty       = w_empty;
  assign bus.almost_full = w_almost_full;
  assign bus.count       = r_count;
  assign bus.overflow    = r_overflow;
  assign bus.underflow   = r_underflow;
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural 8x16 registered-read RAM attached.
module tb_ram_fifo_ctrl;
  logic clk;
  logic clr_n;
  int   n_checks;
  int   n_errors;

  ram_fifo_ctrl_if #(.DW(16), .AW(3)) bus ();

  ram_fifo_ctrl #(.DW(16), .AW(3), .AFULL_TH(6)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: synchronous write, registered read
  logic [15:0] mem [8];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_wr_addr] <= bus.ram_din;
    if (bus.ram_re) bus.ram_dout <= mem[bus.ram_rd_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  // driver tasks: inputs change on the falling edge
  task automatic do_push(input logic [15:0] v);
    @(negedge clk);
    bus.push = 1'b1; bus.din = v; bus.pop = 1'b0; bus.err_clr = 1'b0;
  endtask

  task automatic do_pop();
    @(negedge clk);
    bus.push = 1'b0; bus.pop = 1'b1; bus.err_clr = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.push = 1'b0; bus.pop = 1'b0; bus.err_clr = 1'b0;
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    bus.push = 1'b0; bus.pop = 1'b0; bus.err_clr = 1'b0; bus.din = '0;
    #1;
    n_checks++; if (bus.count !== 4'd0) begin n_errors++; $display("FAIL reset_count: got %0d exp 0", bus.count); end
    n_checks++; if (bus.empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty: got %b exp 1", bus.empty); end
    n_checks++; if (bus.full !== 1'b0 || bus.almost_full !== 1'b0) begin n_errors++; $display("FAIL reset_full_af: got %b%b exp 00", bus.full, bus.almost_full); end
    n_checks++; if (bus.ram_we !== 1'b0 || bus.ram_re !== 1'b0) begin n_errors++; $display("FAIL reset_we_re: got %b%b exp 00", bus.ram_we, bus.ram_re); end
    n_checks++; if (bus.ram_wr_addr !== 3'd0 || bus.ram_rd_addr !== 3'd0) begin n_errors++; $display("FAIL reset_addr: got %0d/%0d exp 0/0", bus.ram_wr_addr, bus.ram_rd_addr); end
    n_checks++; if (bus.dout_valid !== 1'b0 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin n_errors++; $display("FAIL reset_flags: got %b%b%b exp 000", bus.dout_valid, bus.overflow, bus.underflow); end
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      do_push(16'(i + 1));
      #1;
      n_checks++; if (bus.ram_we !== 1'b1) begin n_errors++; $display("FAIL fill_we[%0d]: got %b exp 1", i, bus.ram_we); end
      n_checks++; if (bus.ram_wr_addr !== 3'(i)) begin n_errors++; $display("FAIL fill_addr[%0d]: got %0d exp %0d", i, bus.ram_wr_addr, i); end
      n_checks++; if (bus.ram_din !== 16'(i + 1)) begin n_errors++; $display("FAIL fill_din[%0d]: got %0h exp %0h", i, bus.ram_din, i + 1); end
      n_checks++; if (bus.count !== 4'(i)) begin n_errors++; $display("FAIL fill_count[%0d]: got %0d exp %0d", i, bus.count, i); end
      n_checks++; if (bus.almost_full !== (i >= 6)) begin n_errors++; $display("FAIL fill_af[%0d]: got %b exp %b", i, bus.almost_full, i >= 6); end
    end
    idle();
    #1;
    n_checks++; if (bus.count !== 4'd8) begin n_errors++; $display("FAIL fill_count_end: got %0d exp 8", bus.count); end
    n_checks++; if (bus.full !== 1'b1 || bus.almost_full !== 1'b1) begin n_errors++; $display("FAIL fill_full: got %b%b exp 11", bus.full, bus.almost_full); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_errors++; $display("FAIL fill_ovf: got %b exp 0", bus.overflow); end
  endtask

  task automatic test_overflow();
    do_push(16'hDEAD);
    #1;
    n_checks++; if (bus.ram_we !== 1'b0) begin n_errors++; $display("FAIL ovf_we: got %b exp 0", bus.ram_we); end
    idle();
    bus.err_clr = 1'b1;
    #1;
    n_checks++; if (bus.count !== 4'd8) begin n_errors++; $display("FAIL ovf_count: got %0d exp 8", bus.count); end
    n_checks++; if (bus.overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_set: got %b exp 1", bus.overflow); end
    idle();
    #1;
    n_checks++; if (bus.overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_clr: got %b exp 0", bus.overflow); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      do_pop();
      #1;
      n_checks++; if (bus.ram_re !== 1'b1) begin n_errors++; $display("FAIL drain_re[%0d]: got %b exp 1", i, bus.ram_re); end
      n_checks++; if (bus.ram_rd_addr !== 3'(i)) begin n_errors++; $display("FAIL drain_addr[%0d]: got %0d exp %0d", i, bus.ram_rd_addr, i); end
      if (i > 0) begin
        n_checks++; if (bus.dout_valid !== 1'b1) begin n_errors++; $display("FAIL drain_valid[%0d]: got %b exp 1", i, bus.dout_valid); end
        n_checks++; if (bus.dout !== 16'(i)) begin n_errors++; $display("FAIL drain_dout[%0d]: got %0h exp %0h", i, bus.dout, i); end
      end
    end
    idle();
    #1;
    n_checks++; if (bus.dout_valid !== 1'b1 || bus.dout !== 16'h0008) begin n_errors++; $display("FAIL drain_last: got %b/%0h exp 1/8", bus.dout_valid, bus.dout); end
    n_checks++; if (bus.empty !== 1'b1 || bus.count !== 4'd0) begin n_errors++; $display("FAIL drain_empty: got %b/%0d exp 1/0", bus.empty, bus.count); end
    do_pop();
    #1;
    n_checks++; if (bus.ram_re !== 1'b0) begin n_errors++; $display("FAIL unf_re: got %b exp 0", bus.ram_re); end
    idle();
    #1;
    n_checks++; if (bus.underflow !== 1'b1) begin n_errors++; $display("FAIL unf_set: got %b exp 1", bus.underflow); end
    n_checks++; if (bus.dout_valid !== 1'b0) begin n_errors++; $display("FAIL unf_valid: got %b exp 0", bus.dout_valid); end
    bus.err_clr = 1'b1;
    idle();
    #1;
    n_checks++; if (bus.underflow !== 1'b0) begin n_errors++; $display("FAIL unf_clr: got %b exp 0", bus.underflow); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 5; i++) do_push(16'h0010 + 16'(i));
    for (int i = 0; i < 5; i++) do_pop();
    for (int i = 0; i < 5; i++) begin
      do_push(16'h00A0 + 16'(i));
      #1;
      n_checks++; if (bus.ram_wr_addr !== 3'(5 + i)) begin n_errors++; $display("FAIL wrap_waddr[%0d]: got %0d exp %0d", i, bus.ram_wr_addr, (5 + i) % 8); end
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.push = 1'b0; bus.pop = (k < 5);
      #1;
      if (k < 5) begin
        n_checks++; if (bus.ram_rd_addr !== 3'(5 + k)) begin n_errors++; $display("FAIL wrap_raddr[%0d]: got %0d exp %0d", k, bus.ram_rd_addr, (5 + k) % 8); end
      end
      if (k > 0) begin
        n_checks++; if (bus.dout_valid !== 1'b1 || bus.dout !== 16'h00A0 + 16'(k - 1)) begin n_errors++; $display("FAIL wrap_dout[%0d]: got %b/%0h exp 1/%0h", k, bus.dout_valid, bus.dout, 16'h00A0 + 16'(k - 1)); end
      end
    end
    idle();
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 3; i++) do_push(16'h0030 + 16'(i));
    @(negedge clk);
    bus.push = 1'b1; bus.pop = 1'b1; bus.din = 16'h0033;
    #1;
    n_checks++; if (bus.ram_we !== 1'b1 || bus.ram_re !== 1'b1) begin n_errors++; $display("FAIL sim3_ports: got %b%b exp 11", bus.ram_we, bus.ram_re); end
    idle();
    #1;
    n_checks++; if (bus.count !== 4'd3) begin n_errors++; $display("FAIL sim3_count: got %0d exp 3", bus.count); end
    n_checks++; if (bus.dout_valid !== 1'b1 || bus.dout !== 16'h0030) begin n_errors++; $display("FAIL sim3_dout: got %b/%0h exp 1/30", bus.dout_valid, bus.dout); end
    for (int i = 0; i < 3; i++) do_pop();
    @(negedge clk);
    bus.push = 1'b1; bus.pop = 1'b1; bus.din = 16'h0044;
    #1;
    n_checks++; if (bus.ram_we !== 1'b1 || bus.ram_re !== 1'b0) begin n_errors++; $display("FAIL sim0_ports: got %b%b exp 10", bus.ram_we, bus.ram_re); end
    idle();
    #1;
    n_checks++; if (bus.count !== 4'd1) begin n_errors++; $display("FAIL sim0_count: got %0d exp 1", bus.count); end
    n_checks++; if (bus.dout_valid !== 1'b0) begin n_errors++; $display("FAIL sim0_valid: got %b exp 0", bus.dout_valid); end
    n_checks++; if (bus.underflow !== 1'b1) begin n_errors++; $display("FAIL sim0_unf: got %b exp 1", bus.underflow); end
    for (int i = 0; i < 7; i++) do_push(16'h0050 + 16'(i));
    @(negedge clk);
    bus.push = 1'b1; bus.pop = 1'b1; bus.din = 16'h0077;
    #1;
    n_checks++; if (bus.ram_we !== 1'b1 || bus.ram_re !== 1'b1) begin n_errors++; $display("FAIL sim8_ports: got %b%b exp 11", bus.ram_we, bus.ram_re); end
    idle();
    #1;
    n_checks++; if (bus.count !== 4'd8 || bus.full !== 1'b1) begin n_errors++; $display("FAIL sim8_count: got %0d/%b exp 8/1", bus.count, bus.full); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_errors++; $display("FAIL sim8_ovf: got %b exp 0", bus.overflow); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) do_pop();
    idle();
    #1;
    n_checks++; if (bus.count !== 4'd4) begin n_errors++; $display("FAIL mid_pre_count: got %0d exp 4", bus.count); end
    do_pop();
    @(posedge clk);
    #1;
    n_checks++; if (bus.dout_valid !== 1'b1) begin n_errors++; $display("FAIL mid_pre_valid: got %b exp 1", bus.dout_valid); end
    clr_n = 1'b0;
    bus.pop = 1'b0;
    #1;
    n_checks++; if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin n_errors++; $display("FAIL mid_count: got %0d/%b exp 0/1", bus.count, bus.empty); end
    n_checks++; if (bus.dout_valid !== 1'b0) begin n_errors++; $display("FAIL mid_valid: got %b exp 0", bus.dout_valid); end
    n_checks++; if (bus.underflow !== 1'b0 || bus.ram_rd_addr !== 3'd0) begin n_errors++; $display("FAIL mid_state: got %b/%0d exp 0/0", bus.underflow, bus.ram_rd_addr); end
    @(negedge clk);
    clr_n = 1'b1;
    bus.pop = 1'b1;
    #1;
    n_checks++; if (bus.ram_re !== 1'b0) begin n_errors++; $display("FAIL post_re: got %b exp 0", bus.ram_re); end
    idle();
    #1;
    n_checks++; if (bus.dout_valid !== 1'b0 || bus.underflow !== 1'b1) begin n_errors++; $display("FAIL post_pop: got %b/%b exp 0/1", bus.dout_valid, bus.underflow); end
    do_push(16'hBEEF);
    do_pop();
    #1;
    n_checks++; if (bus.ram_re !== 1'b1 || bus.ram_rd_addr !== 3'd0) begin n_errors++; $display("FAIL post_re2: got %b/%0d exp 1/0", bus.ram_re, bus.ram_rd_addr); end
    idle();
    #1;
    n_checks++; if (bus.dout_valid !== 1'b1 || bus.dout !== 16'hBEEF) begin n_errors++; $display("FAIL post_dout: got %b/%0h exp 1/beef", bus.dout_valid, bus.dout); end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
